// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: owns the PC, issues word fetches and
// buffers tagged instructions toward decode, with redirect flush.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_valid_o,
    input  logic        imem_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_instr_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TQ = 1 << OW;

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   pc_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [OW-1:0] outst_q, outst_d, drop_q;
    logic [31:0]   tag_q [TQ];

    logic          pop, fire, rsp, keep, credit_ok;
    logic [31:0]   occ;
    logic [OW-1:0] tag_idx;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc_i[1:0];

    assign pop = (count_q != '0) && if_ready_i;
    assign occ = 32'(count_q) + 32'(outst_q) - {31'b0, pop};
    assign credit_ok = (occ < 32'(FIFO_DEPTH))
                    && (32'(outst_q) < 32'(MAX_OUTSTANDING));

    always_comb begin
        state_d      = state_q;
        imem_valid_o = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN:  imem_valid_o = credit_ok && !redirect_i;
        endcase
    end

    assign fire    = imem_valid_o && imem_ready_i;
    assign rsp     = imem_valid_i && (outst_q != '0);
    assign keep    = rsp && (drop_q == '0) && !redirect_i;
    assign outst_d = outst_q + OW'(fire) - OW'(rsp);
    // New tag lands behind the entries that survive this cycle's pop
    assign tag_idx = outst_q - OW'(rsp);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            if (redirect_i) begin
                pc_q   <= {redirect_pc_i[31:2], 2'b00};
                drop_q <= outst_d;
            end else begin
                if (fire) pc_q <= pc_q + 32'd4;
                if (rsp && (drop_q != '0)) drop_q <= drop_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TQ; i++) tag_q[i] <= '0;
        end else begin
            if (rsp) begin
                for (int i = 0; i < TQ - 1; i++) tag_q[i] <= tag_q[i+1];
            end
            if (fire) tag_q[tag_idx] <= pc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else if (redirect_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (keep) begin
                fifo_pc_q[wr_ptr_q]    <= tag_q[0];
                fifo_instr_q[wr_ptr_q] <= imem_instr_i;
                wr_ptr_q               <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(keep) - CW'(pop);
        end
    end

    assign imem_addr_o = pc_q;
    assign if_valid_o  = (count_q != '0);
    assign if_pc_o     = fifo_pc_q[rd_ptr_q];
    assign if_instr_o  = fifo_instr_q[rd_ptr_q];
    assign busy_o      = (outst_q != '0) || (drop_q != '0);

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: boot vector table, scoreboard
// monitor and hand-written stall / redirect / async-reset sequences.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FDEPTH   = 2;
    localparam int          MAXOUT   = 2;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_valid_o;
    logic        imem_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_instr_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    ifetch_unit #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (FDEPTH),
        .MAX_OUTSTANDING(MAXOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_valid_o (imem_valid_o),
        .imem_ready_i (imem_ready_i),
        .imem_addr_o  (imem_addr_o),
        .imem_valid_i (imem_valid_i),
        .imem_instr_i (imem_instr_i),
        .if_valid_o   (if_valid_o),
        .if_ready_i   (if_ready_i),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: fixed 1-cycle latency, instr = addr ^ KEY
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imem_valid_i <= 1'b0;
            imem_instr_i <= '0;
        end else begin
            imem_valid_i <= imem_valid_o && imem_ready_i;
            imem_instr_i <= imem_addr_o ^ KEY;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    ent_t        e;
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] exp_dec   = RESET_PC;
    logic        stall_q   = 1'b0;
    logic [31:0] hold_addr = '0;

    always @(negedge rst_ni) begin
        sb.delete();
        exp_fetch = RESET_PC;
        exp_dec   = RESET_PC;
        stall_q   = 1'b0;
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (if_valid_o && if_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got pc %h expected none",
                             if_pc_o);
                end else begin
                    e = sb.pop_front();
                    chk("dec_pc", if_pc_o, e.pc);
                    chk("dec_instr", if_instr_o, e.instr);
                end
                chk("dec_seq", if_pc_o, exp_dec);
                exp_dec = exp_dec + 32'd4;
            end
            if (redirect_i) chk("redir_noreq", {31'b0, imem_valid_o}, 0);
            if (stall_q && !redirect_i) begin
                chk("hold_valid", {31'b0, imem_valid_o}, 1);
                chk("hold_addr", imem_addr_o, hold_addr);
            end
            if (imem_valid_o && imem_ready_i) begin
                chk("fetch_addr", imem_addr_o, exp_fetch);
                sb.push_back('{exp_fetch, exp_fetch ^ KEY});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (sb.size() > FDEPTH) begin
                checks++;
                failures++;
                $display("FAIL depth: got %0d expected <= %0d",
                         sb.size(), FDEPTH);
            end
            if (redirect_i) begin
                sb.delete();
                exp_fetch = {redirect_pc_i[31:2], 2'b00};
                exp_dec   = {redirect_pc_i[31:2], 2'b00};
            end
            stall_q   = imem_valid_o && !imem_ready_i;
            hold_addr = imem_addr_o;
        end
    end

    typedef struct {
        logic        imem_rdy;
        logic        if_rdy;
        logic        x_ivalid;
        logic [31:0] x_iaddr;
        logic        x_fvalid;
        logic [31:0] x_fpc;
    } vec_t;

    vec_t tbl[7];

    task automatic run_boot();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                @(posedge clk_i);
                #1;
            end
            imem_ready_i = tbl[i].imem_rdy;
            if_ready_i   = tbl[i].if_rdy;
            redirect_i   = 1'b0;
            rst_ni       = 1'b1;
            @(negedge clk_i);
            chk($sformatf("boot%0d_ivalid", i),
                {31'b0, imem_valid_o}, {31'b0, tbl[i].x_ivalid});
            chk($sformatf("boot%0d_iaddr", i), imem_addr_o, tbl[i].x_iaddr);
            chk($sformatf("boot%0d_fvalid", i),
                {31'b0, if_valid_o}, {31'b0, tbl[i].x_fvalid});
            chk($sformatf("boot%0d_pc", i), if_pc_o, tbl[i].x_fpc);
            chk($sformatf("boot%0d_instr", i), if_instr_o,
                tbl[i].x_fvalid ? (tbl[i].x_fpc ^ KEY) : 32'h0);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};

        rst_ni        = 1'b0;
        imem_ready_i  = 1'b0;
        if_ready_i    = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        run_boot();

        // Decode back-pressure
        step();
        if_ready_i = 1'b0;
        repeat (4) step();
        @(negedge clk_i);
        chk("bp_ivalid", {31'b0, imem_valid_o}, 0);
        chk("bp_fvalid", {31'b0, if_valid_o}, 1);
        step();
        if_ready_i = 1'b1;
        repeat (6) step();

        // Memory stall: addr holds at 8
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0;
        step();
        redirect_i = 1'b0;
        step();
        step();
        imem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("st1_addr", imem_addr_o, 32'd8);
        step();
        @(negedge clk_i);
        chk("st2_addr", imem_addr_o, 32'd8);
        chk("st2_valid", {31'b0, imem_valid_o}, 1);
        step();
        imem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("st3_addr", imem_addr_o, 32'd8);
        repeat (4) step();

        // Redirect with one response outstanding
        @(negedge clk_i);
        chk("pre_fire", {31'b0, imem_valid_o && imem_ready_i}, 1);
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        @(negedge clk_i);
        chk("r1_busy", {31'b0, busy_o}, 1);
        step();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("r1_fvalid_a", {31'b0, if_valid_o}, 0);
        chk("r1_busy_idle", {31'b0, busy_o}, 0);
        chk("r1_addr", imem_addr_o, 32'h0000_0100);
        step();
        @(negedge clk_i);
        chk("r1_fvalid_b", {31'b0, if_valid_o}, 0);
        step();
        @(negedge clk_i);
        chk("r1_fvalid_c", {31'b0, if_valid_o}, 1);
        chk("r1_pc", if_pc_o, 32'h0000_0100);
        chk("r1_instr", if_instr_o, 32'h0000_0100 ^ KEY);
        repeat (3) step();

        // Back-to-back redirects
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        step();
        redirect_pc_i = 32'h0000_0300;
        step();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("r2_addr", imem_addr_o, 32'h0000_0300);
        chk("r2_ivalid", {31'b0, imem_valid_o}, 1);
        step();
        @(negedge clk_i);
        chk("r2_fvalid", {31'b0, if_valid_o}, 0);
        step();
        @(negedge clk_i);
        chk("r2_pc", if_pc_o, 32'h0000_0300);
        chk("r2_fvalid2", {31'b0, if_valid_o}, 1);
        repeat (3) step();

        // Asynchronous reset mid-stream
        #1;
        rst_ni = 1'b0;
        #1;
        chk("ar_ivalid", {31'b0, imem_valid_o}, 0);
        chk("ar_iaddr", imem_addr_o, RESET_PC);
        chk("ar_fvalid", {31'b0, if_valid_o}, 0);
        chk("ar_pc", if_pc_o, 0);
        chk("ar_instr", if_instr_o, 0);
        chk("ar_busy", {31'b0, busy_o}, 0);
        repeat (2) @(posedge clk_i);
        #1;
        run_boot();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
